// File: rtl/mul_share_pkg.sv
// Shared constants and the round-robin pick helper for the shared-multiplier arbiter.
package mul_share_pkg;

    localparam int MUL_W   = 8;
    localparam int PROD_W  = 16;
    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, wrapping within the low n bits.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input logic [3:0]         n);
        rr_pick_t   r;
        logic [3:0] idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((4'(k) < n) && !r.found && valid[idx[2:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mul8_pipe.sv
// Two-stage enabled 8x8 unsigned multiplier carrying a valid/id sideband.
module mul8_pipe
    import mul_share_pkg::*;
#(
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_v,
    input  logic [IDW-1:0]    in_id,
    input  logic [MUL_W-1:0]  in_a,
    input  logic [MUL_W-1:0]  in_b,
    output logic              out_v,
    output logic [IDW-1:0]    out_id,
    output logic [PROD_W-1:0] out_p,
    output logic              busy
);

    logic              v1_q, v1_d;
    logic [IDW-1:0]    id1_q, id1_d;
    logic [MUL_W-1:0]  a1_q, a1_d;
    logic [MUL_W-1:0]  b1_q, b1_d;
    logic              v2_q, v2_d;
    logic [IDW-1:0]    id2_q, id2_d;
    logic [PROD_W-1:0] p2_q, p2_d;

    always_comb begin
        v1_d  = v1_q;
        id1_d = id1_q;
        a1_d  = a1_q;
        b1_d  = b1_q;
        v2_d  = v2_q;
        id2_d = id2_q;
        p2_d  = p2_q;
        if (en) begin
            // A bubble only clears v1; operand registers keep their old contents.
            v1_d = in_v;
            if (in_v) begin
                id1_d = in_id;
                a1_d  = in_a;
                b1_d  = in_b;
            end
            v2_d  = v1_q;
            id2_d = id1_q;
            p2_d  = PROD_W'(a1_q) * PROD_W'(b1_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            id1_q <= '0;
            a1_q  <= '0;
            b1_q  <= '0;
            v2_q  <= 1'b0;
            id2_q <= '0;
            p2_q  <= '0;
        end else begin
            v1_q  <= v1_d;
            id1_q <= id1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            v2_q  <= v2_d;
            id2_q <= id2_d;
            p2_q  <= p2_d;
        end
    end

    assign out_v  = v2_q;
    assign out_id = id2_q;
    assign out_p  = p2_q;
    assign busy   = v1_q | v2_q;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined 8x8 multiplier among NREQ requesters.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ena,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*MUL_W-1:0] req_a,
    input  logic [NREQ*MUL_W-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [PROD_W-1:0]     rsp_p,
    input  logic                  rsp_ready,
    output logic                  busy
);

    logic             adv;
    logic             grant_en;
    rr_pick_t         pick;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [IDW-1:0]   grant_id;
    logic [MUL_W-1:0] a_sel, b_sel;

    // The whole pipeline freezes only when a response is stuck at the output.
    assign adv      = !rsp_valid | rsp_ready;
    assign pick     = rr_pick(MAX_REQ'(req_valid), 3'(rr_q), 4'(NREQ));
    assign grant_en = !reset & ena & adv & pick.found;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en & (pick.idx == 3'(gi));
        end
    endgenerate

    always_comb begin
        grant_id = '0;
        a_sel    = '0;
        b_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                grant_id = IDW'(i);
                a_sel    = req_a[MUL_W*i +: MUL_W];
                b_sel    = req_b[MUL_W*i +: MUL_W];
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_en) begin
            rr_d = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    mul8_pipe #(
        .IDW(IDW)
    ) u_pipe (
        .clk   (clk),
        .reset (reset),
        .en    (adv),
        .in_v  (grant_en),
        .in_id (grant_id),
        .in_a  (a_sel),
        .in_b  (b_sel),
        .out_v (rsp_valid),
        .out_id(rsp_id),
        .out_p (rsp_p),
        .busy  (busy)
    );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: acceptances push expected results, a monitor checks responses.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_p;
    logic        rsp_ready;
    logic        busy;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] p;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    logic [15:0] exp_prod [4];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [3:0]  acc;

    mul_share_arbiter #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ena      (ena),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id   (rsp_id),
        .rsp_p    (rsp_p),
        .rsp_ready(rsp_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        exp_prod[i]     = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    // Acceptance monitor: log grants and push the hand-computed product.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("req_ready_onehot0", 32'($onehot0(req_ready)), 1);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = 2'(i);
                    e.p  = exp_prod[i];
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                    $display("accept id=%0d a=%0d b=%0d", i, req_a[8*i +: 8], req_b[8*i +: 8]);
                end
            end
        end
    end

    // Response monitor: compare retired responses and check backpressure stability.
    bit          hold_q = 1'b0;
    logic [1:0]  hold_id;
    logic [15:0] hold_p;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            hold_q = 1'b0;
        end else begin
            if (rsp_valid && !rsp_ready) begin
                chk("bp_req_ready_zero", 32'(req_ready), 0);
                if (hold_q) begin
                    chk("bp_id_stable", 32'(rsp_id), 32'(hold_id));
                    chk("bp_p_stable", 32'(rsp_p), 32'(hold_p));
                end
                hold_q  = 1'b1;
                hold_id = rsp_id;
                hold_p  = rsp_p;
            end else begin
                hold_q = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
                $display("response id=%0d p=%0d", rsp_id, rsp_p);
                if (exp_q.size() == 0) begin
                    chk("spurious_rsp", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_p", 32'(rsp_p), 32'(e.p));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};

        // Reset with all requesters valid: outputs and grants must be zero.
        reset     = 1'b1;
        ena       = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < 4; i++) exp_prod[i] = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_rsp_p", 32'(rsp_p), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_req_ready", 32'(req_ready), 0);
        tick();

        // Single request, latency 2.
        reset     = 1'b0;
        req_valid = 4'b0010;
        set_op(1, 8'd12, 8'd10, 16'd120);
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_latency_n1", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("t1_latency_n2", 32'(rsp_valid), 1);
        wait_drain();

        // Round-robin from a fresh pointer.
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        grant_log.delete();
        set_op(0, 8'd1, 8'd3, 16'd3);
        set_op(1, 8'd2, 8'd3, 16'd6);
        set_op(2, 8'd3, 8'd3, 16'd9);
        set_op(3, 8'd4, 8'd3, 16'd12);
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) chk("t2_stream_valid", 32'(rsp_valid), 1);
            tick();
            if (c == 4) req_valid = 4'b0000;
        end
        chk("t2_num_grants", 32'(grant_log.size()), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_log.size()) chk("t2_grant_order", 32'(grant_log[k]), 32'(exp_order[k]));
        end
        wait_drain();

        // Backpressure: three requests, response port stalled.
        rsp_ready = 1'b0;
        set_op(1, 8'd5, 8'd10, 16'd50);
        set_op(2, 8'd6, 8'd10, 16'd60);
        set_op(3, 8'd7, 8'd10, 16'd70);
        req_valid = 4'b1110;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) chk("t3_stall_valid", 32'(rsp_valid), 1);
            acc = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~acc;
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~acc;
        end
        chk("t3_all_accepted", 32'(req_valid), 0);
        wait_drain();

        // Pointer to 3, then wrap to requester 0 with boundary products.
        req_valid = 4'b0100;
        set_op(2, 8'd1, 8'd1, 16'd1);
        @(negedge clk);
        chk("t4_grant2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0001;
        set_op(0, 8'd255, 8'd255, 16'hFE01);
        @(negedge clk);
        chk("t4_wrap_grant", 32'(req_ready), 32'b0001);
        tick();
        set_op(0, 8'd0, 8'd200, 16'd0);
        @(negedge clk);
        chk("t4_grant0_again", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0011;
        set_op(1, 8'd2, 8'd9, 16'd18);
        @(negedge clk);
        chk("t4_rr_after_wrap", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0000;
        wait_drain();

        // ena gating: two in flight, requests pending, pipeline drains.
        set_op(0, 8'd10, 8'd2, 16'd20);
        set_op(1, 8'd11, 8'd2, 16'd22);
        set_op(2, 8'd12, 8'd2, 16'd24);
        set_op(3, 8'd13, 8'd2, 16'd26);
        req_valid = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            req_valid = req_valid & ~acc;
        end
        ena = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_no_grant", 32'(req_ready), 0);
            if (c == 0) chk("t5_busy_high", 32'(busy), 1);
            tick();
        end
        @(negedge clk);
        chk("t5_busy_low", 32'(busy), 0);
        chk("t5_drained", 32'(exp_q.size()), 0);
        tick();
        req_valid = 4'b0000;
        ena       = 1'b1;

        // Reset mid-flight discards work and returns the pointer to 0.
        set_op(0, 8'd1, 8'd3, 16'd3);
        set_op(1, 8'd2, 8'd3, 16'd6);
        set_op(2, 8'd3, 8'd3, 16'd9);
        set_op(3, 8'd4, 8'd3, 16'd12);
        tick();
        req_valid = 4'b0110;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        reset = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t6_reset_ready", 32'(req_ready), 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("t6_post_reset_rsp", 32'(rsp_valid), 0);
        chk("t6_post_reset_grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        @(negedge clk);
        chk("t6_no_stale_rsp", 32'(rsp_valid), 0);
        wait_drain();

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
